// File: rtl/npu_input_loader_if.sv
// npu_input_loader_if: element stream in, packed vector out; s_last/frame_err exist only with NPU_LOADER_LAST_CHECK_EN
interface npu_input_loader_if #(
  parameter int IN_N       = 4,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]      s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic [IN_N*DATA_WIDTH-1:0] m_vec;
  logic                       m_valid;
  logic                       m_ready;
`ifdef NPU_LOADER_LAST_CHECK_EN
  logic                       s_last;
  logic                       frame_err;
  modport slave  (input s_data, s_valid, s_last, m_ready, output s_ready, m_vec, m_valid, frame_err);
  modport master (output s_data, s_valid, s_last, m_ready, input s_ready, m_vec, m_valid, frame_err);
`else
  modport slave  (input s_data, s_valid, m_ready, output s_ready, m_vec, m_valid);
  modport master (output s_data, s_valid, m_ready, input s_ready, m_vec, m_valid);
`endif
endinterface

// File: rtl/npu_input_loader.sv
// npu_input_loader: ping-pong stream-to-vector loader; NPU_LOADER_LAST_CHECK_EN enables s_last framing checks
module npu_input_loader #(
  parameter int IN_N       = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  npu_input_loader_if.slave bus
);
  localparam int CW = $clog2(IN_N);
  localparam logic [CW-1:0] LAST = CW'(IN_N - 1);
  logic [1:0][IN_N-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [CW-1:0] elem_cnt_q, elem_cnt_d;
  logic          accept, consume, done, last_in;
`ifdef NPU_LOADER_LAST_CHECK_EN
  logic frame_err_q, frame_err_d;
  assign last_in       = bus.s_last;
  assign bus.frame_err = frame_err_q;
`else
  assign last_in = 1'b0;
`endif
  assign bus.s_ready = !full_q[wr_bank_q];
  assign bus.m_valid = full_q[rd_bank_q];
  assign bus.m_vec   = mem_q[rd_bank_q];
  assign accept      = bus.s_valid && bus.s_ready;
  assign consume     = bus.m_valid && bus.m_ready;
  assign done        = accept && (elem_cnt_q == LAST || last_in);
  // write beats into the fill bank, close frames early on s_last with zero-fill, free banks on consume
  always_comb begin
    mem_d      = mem_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    elem_cnt_d = elem_cnt_q;
    if (accept) begin
      mem_d[wr_bank_q][elem_cnt_q] = bus.s_data;
      elem_cnt_d = done ? '0 : elem_cnt_q + CW'(1);
    end
    if (done) begin
      for (int k = 0; k < IN_N; k++) if (CW'(k) > elem_cnt_q) mem_d[wr_bank_q][k] = '0;
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d = !wr_bank_q;
    end
    if (consume) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d = !rd_bank_q;
    end
  end
`ifdef NPU_LOADER_LAST_CHECK_EN
  // flag frames whose s_last does not coincide with the final element
  always_comb frame_err_d = accept && (last_in ? elem_cnt_q != LAST : elem_cnt_q == LAST);
  // framing-error pulse register
  always_ff @(posedge clk) frame_err_q <= rst ? 1'b0 : frame_err_d;
`endif
  // bank state registers; reset overrides any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      elem_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      elem_cnt_q <= elem_cnt_d;
    end
  end
endmodule

// File: tb/tb_npu_input_loader.sv
// tb_npu_input_loader: directed vector table plus hand-written sequences for npu_input_loader
module tb_npu_input_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  npu_input_loader_if #(.IN_N(4), .DATA_WIDTH(8)) bus();
  npu_input_loader #(.IN_N(4), .DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic        cv;
    logic [31:0] e_vec;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic mr);
    rst = r;
    bus.s_valid = v;
    bus.s_data = d;
    bus.m_ready = mr;
  endtask
  initial begin
    drive(1, 0, 0, 0);
`ifdef NPU_LOADER_LAST_CHECK_EN
    bus.s_last = 1'b0;
`endif
    tick();
    tv.push_back('{1, 0, 8'h00, 0, 1, 0, 1, 32'h0});
    tv.push_back('{0, 1, 8'h01, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'h02, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'h03, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'h80, 1, 1, 1, 1, 32'h80030201});
    tv.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'h10, 0, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'h11, 0, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'h12, 0, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'h13, 0, 1, 1, 1, 32'h13121110});
    tv.push_back('{0, 1, 8'h14, 0, 1, 1, 1, 32'h13121110});
    tv.push_back('{0, 1, 8'h15, 0, 1, 1, 1, 32'h13121110});
    tv.push_back('{0, 1, 8'h16, 0, 1, 1, 1, 32'h13121110});
    tv.push_back('{0, 1, 8'h17, 0, 0, 1, 1, 32'h13121110});
    tv.push_back('{0, 1, 8'h18, 0, 0, 1, 1, 32'h13121110});
    tv.push_back('{0, 1, 8'h18, 1, 1, 1, 1, 32'h17161514});
    tv.push_back('{0, 1, 8'h18, 0, 1, 1, 1, 32'h17161514});
    tv.push_back('{0, 1, 8'h19, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'h1A, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'h1B, 1, 1, 1, 1, 32'h1B1A1918});
    tv.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'hA0, 0, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'hA1, 0, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'hA2, 0, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'hA3, 0, 1, 1, 1, 32'hA3A2A1A0});
    tv.push_back('{0, 1, 8'hB0, 0, 1, 1, 1, 32'hA3A2A1A0});
    tv.push_back('{0, 1, 8'hB1, 0, 1, 1, 1, 32'hA3A2A1A0});
    tv.push_back('{1, 1, 8'hB2, 1, 1, 0, 1, 32'h0});
    tv.push_back('{0, 1, 8'hC0, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'hC1, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'hC2, 1, 1, 0, 0, 32'h0});
    tv.push_back('{0, 1, 8'hC3, 1, 1, 1, 1, 32'hC3C2C1C0});
    tv.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 32'h0});
    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].v, tv[i].d, tv[i].mr);
      tick();
      chk($sformatf("row%0d_s_ready", i), bus.s_ready, tv[i].e_sr);
      chk($sformatf("row%0d_m_valid", i), bus.m_valid, tv[i].e_mv);
      if (tv[i].cv) chk($sformatf("row%0d_m_vec", i), bus.m_vec, tv[i].e_vec);
    end
    drive(1, 0, 0, 1);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'(8'h40 + i), 1);
      tick();
      chk($sformatf("t3_s_ready%0d", i), bus.s_ready, 1);
      chk($sformatf("t3_m_valid%0d", i), bus.m_valid, 32'(i % 4 == 3));
      if (i % 4 == 3) chk($sformatf("t3_m_vec%0d", i), bus.m_vec, {8'(8'h40 + i), 8'(8'h3F + i), 8'(8'h3E + i), 8'(8'h3D + i)});
    end
    drive(0, 0, 0, 1);
    tick();
    chk("t3_drain", bus.m_valid, 0);
`ifdef NPU_LOADER_LAST_CHECK_EN
    drive(1, 0, 0, 0);
    tick();
    chk("t5_rst_err", bus.frame_err, 0);
    drive(0, 1, 8'h11, 0);
    tick();
    chk("t5_b0_err", bus.frame_err, 0);
    drive(0, 1, 8'h22, 0);
    bus.s_last = 1'b1;
    tick();
    chk("t5_short_mv", bus.m_valid, 1);
    chk("t5_short_vec", bus.m_vec, 32'h00002211);
    chk("t5_short_err", bus.frame_err, 1);
    drive(0, 0, 0, 1);
    bus.s_last = 1'b0;
    tick();
    chk("t5_pulse_end", bus.frame_err, 0);
    chk("t5_consumed", bus.m_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 8'(i), 1);
      bus.s_last = (i == 4);
      tick();
      chk($sformatf("t5_good_err%0d", i), bus.frame_err, 0);
    end
    chk("t5_good_vec", bus.m_vec, 32'h04030201);
    chk("t5_good_mv", bus.m_valid, 1);
    drive(0, 0, 0, 1);
    bus.s_last = 1'b0;
    tick();
    chk("t5_good_after", bus.frame_err, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'(8'h55 + 8'h11 * i), 0);
      tick();
    end
    chk("t6_miss_mv", bus.m_valid, 1);
    chk("t6_miss_vec", bus.m_vec, 32'h88776655);
    chk("t6_miss_err", bus.frame_err, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'(8'h99 + 8'h11 * i), 1);
      bus.s_last = (i == 3);
      tick();
      chk($sformatf("t6_next_err%0d", i), bus.frame_err, 0);
    end
    chk("t6_next_mv", bus.m_valid, 1);
    chk("t6_next_vec", bus.m_vec, 32'hCCBBAA99);
    bus.s_last = 1'b0;
`endif
    drive(0, 0, 0, 1);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
